// File: rtl/sbus_pkg.sv
// Shared types and constants for the two-requester single-port bus arbiter.
// Requester IDs double as the round-robin pointer value and the read-tag id.
package sbus_pkg;

    localparam int SBUS_ADDR_W = 32;
    localparam int SBUS_DATA_W = 32;
    localparam int SBUS_STRB_W = SBUS_DATA_W / 8;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_FAB  = 1'b1;

    typedef struct packed {
        logic                   we;
        logic [SBUS_ADDR_W-1:0] addr;
        logic [SBUS_DATA_W-1:0] wdata;
        logic [SBUS_STRB_W-1:0] wstrb;
    } sbus_cmd_t;

    // Travels alongside a read so the returning data reaches the right requester.
    typedef struct packed {
        logic id;
        logic err;
        logic is_rd;
    } sbus_tag_t;

endpackage

// File: rtl/sbus_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered last-winner pointer.
// On a tie the requester that did not win last time is granted.
module sbus_rr_arb2
    import sbus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == REQ_FAB) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            last_grant_d = REQ_HOST;
        end else if (gnt[1]) begin
            last_grant_d = REQ_FAB;
        end
    end

    // Pointer resets to fabric so the host wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_FAB;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sbus_arbiter.sv
// Shares one single-port memory bus between a host and a fabric requester:
// round-robin accept, registered memory strobes, tagged read return, range check.
module sbus_arbiter
    import sbus_pkg::*;
#(
    parameter int ADDR_W    = SBUS_ADDR_W,
    parameter int DATA_W    = SBUS_DATA_W,
    parameter int MEM_WORDS = 1024
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,

    input  logic                h_valid,
    output logic                h_ready,
    input  logic                h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    input  logic [DATA_W/8-1:0] h_wstrb,
    output logic                h_wack,
    output logic                h_rvalid,
    output logic [DATA_W-1:0]   h_rdata,
    output logic                h_err,

    input  logic                f_valid,
    output logic                f_ready,
    input  logic                f_we,
    input  logic [ADDR_W-1:0]   f_addr,
    input  logic [DATA_W-1:0]   f_wdata,
    input  logic [DATA_W/8-1:0] f_wstrb,
    output logic                f_wack,
    output logic                f_rvalid,
    output logic [DATA_W-1:0]   f_rdata,
    output logic                f_err,

    output logic                o_we,
    output logic [ADDR_W-1:0]   o_waddr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_rd,
    output logic [ADDR_W-1:0]   o_raddr,
    input  logic [DATA_W-1:0]   i_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel_id;
    logic       accept;
    logic       sel_in_range;
    sbus_cmd_t  sel_cmd;
    logic       wr_ack;
    logic       wr_err;

    logic              o_we_q,    o_we_d;
    logic [ADDR_W-1:0] o_waddr_q, o_waddr_d;
    logic [DATA_W-1:0] o_wdata_q, o_wdata_d;
    logic [STRB_W-1:0] o_wstrb_q, o_wstrb_d;
    logic              o_rd_q,    o_rd_d;
    logic [ADDR_W-1:0] o_raddr_q, o_raddr_d;
    sbus_tag_t         tag1_q,    tag1_d;
    sbus_tag_t         tag2_q;

    assign req = {f_valid, h_valid};

    sbus_rr_arb2 u_arb (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .req   (req),
        .gnt   (gnt)
    );

    assign h_ready = gnt[0];
    assign f_ready = gnt[1];

    always_comb begin
        sel_id = gnt[1];
        accept = |gnt;
        if (sel_id == REQ_FAB) begin
            sel_cmd.we    = f_we;
            sel_cmd.addr  = f_addr;
            sel_cmd.wdata = f_wdata;
            sel_cmd.wstrb = f_wstrb;
        end else begin
            sel_cmd.we    = h_we;
            sel_cmd.addr  = h_addr;
            sel_cmd.wdata = h_wdata;
            sel_cmd.wstrb = h_wstrb;
        end
        sel_in_range = ({1'b0, sel_cmd.addr} < MEM_LIMIT);

        wr_ack = accept && sel_cmd.we;
        wr_err = !sel_in_range;

        // An empty byte mask still completes the handshake but never touches memory.
        o_we_d    = wr_ack && sel_in_range && (|sel_cmd.wstrb);
        o_waddr_d = o_we_d ? sel_cmd.addr  : o_waddr_q;
        o_wdata_d = o_we_d ? sel_cmd.wdata : o_wdata_q;
        o_wstrb_d = o_we_d ? sel_cmd.wstrb : o_wstrb_q;

        o_rd_d    = accept && !sel_cmd.we && sel_in_range;
        o_raddr_d = o_rd_d ? sel_cmd.addr : o_raddr_q;

        tag1_d = '0;
        if (accept && !sel_cmd.we) begin
            tag1_d.id    = sel_id;
            tag1_d.err   = !sel_in_range;
            tag1_d.is_rd = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            o_we_q    <= 1'b0;
            o_waddr_q <= '0;
            o_wdata_q <= '0;
            o_wstrb_q <= '0;
            o_rd_q    <= 1'b0;
            o_raddr_q <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
        end else begin
            o_we_q    <= o_we_d;
            o_waddr_q <= o_waddr_d;
            o_wdata_q <= o_wdata_d;
            o_wstrb_q <= o_wstrb_d;
            o_rd_q    <= o_rd_d;
            o_raddr_q <= o_raddr_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag1_q;
        end
    end

    assign o_we    = o_we_q;
    assign o_waddr = o_waddr_q;
    assign o_wdata = o_wdata_q;
    assign o_wstrb = o_wstrb_q;
    assign o_rd    = o_rd_q;
    assign o_raddr = o_raddr_q;

    // Per-requester response registers; tag2 lines up with i_rdata from the memory.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic              wack_q,   wack_d;
        logic              rvalid_q, rvalid_d;
        logic              err_q,    err_d;
        logic [DATA_W-1:0] rdata_q,  rdata_d;

        always_comb begin
            wack_d   = wr_ack && (sel_id == 1'(gi));
            rvalid_d = tag2_q.is_rd && (tag2_q.id == 1'(gi));
            rdata_d  = rdata_q;
            if (rvalid_d) begin
                rdata_d = tag2_q.err ? '0 : i_rdata;
            end
            err_d = (wack_d && wr_err) || (rvalid_d && tag2_q.err);
        end

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                wack_q   <= 1'b0;
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
                rdata_q  <= '0;
            end else begin
                wack_q   <= wack_d;
                rvalid_q <= rvalid_d;
                err_q    <= err_d;
                rdata_q  <= rdata_d;
            end
        end
    end

    assign h_wack   = g_rsp[0].wack_q;
    assign h_rvalid = g_rsp[0].rvalid_q;
    assign h_rdata  = g_rsp[0].rdata_q;
    assign h_err    = g_rsp[0].err_q;
    assign f_wack   = g_rsp[1].wack_q;
    assign f_rvalid = g_rsp[1].rvalid_q;
    assign f_rdata  = g_rsp[1].rdata_q;
    assign f_err    = g_rsp[1].err_q;

endmodule

// File: tb/tb_sbus_arbiter.sv
// Bench for sbus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (queues of expected responses, reference memory).
module tb_sbus_arbiter;

    localparam int MEM_WORDS = 1024;
    localparam int NCYC      = 300;

    typedef struct {
        int          cyc;
        logic        rid;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic        h_valid, h_ready, h_we, h_wack, h_rvalid, h_err;
    logic [31:0] h_addr, h_wdata, h_rdata;
    logic [3:0]  h_wstrb;
    logic        f_valid, f_ready, f_we, f_wack, f_rvalid, f_err;
    logic [31:0] f_addr, f_wdata, f_rdata;
    logic [3:0]  f_wstrb;
    logic        o_we, o_rd;
    logic [31:0] o_waddr, o_wdata, o_raddr;
    logic [3:0]  o_wstrb;
    logic [31:0] i_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [MEM_WORDS];

    sbus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MEM_WORDS)) dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_wstrb(h_wstrb), .h_wack(h_wack), .h_rvalid(h_rvalid),
        .h_rdata(h_rdata), .h_err(h_err),
        .f_valid(f_valid), .f_ready(f_ready), .f_we(f_we), .f_addr(f_addr),
        .f_wdata(f_wdata), .f_wstrb(f_wstrb), .f_wack(f_wack), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .o_rd(o_rd), .o_raddr(o_raddr), .i_rdata(i_rdata)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    // Single-port memory with a registered read; garbage on the data bus when not read.
    always @(posedge S_AXI_ACLK) begin
        if (o_we && o_waddr < MEM_WORDS) begin
            for (int b = 0; b < 4; b++) begin
                if (o_wstrb[b]) mem[o_waddr[9:0]][8*b +: 8] <= o_wdata[8*b +: 8];
            end
        end
        if (o_rd && o_raddr < MEM_WORDS) i_rdata <= mem[o_raddr[9:0]];
        else                             i_rdata <= $urandom;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    task automatic drive_idle();
        h_valid = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_wstrb = 0;
        f_valid = 0; f_we = 0; f_addr = 0; f_wdata = 0; f_wstrb = 0;
    endtask

    task automatic drive_h(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        h_valid = 1; h_we = we; h_addr = addr; h_wdata = data; h_wstrb = strb;
    endtask

    task automatic drive_f(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        f_valid = 1; f_we = we; f_addr = addr; f_wdata = data; f_wstrb = strb;
    endtask

    task automatic test_reset();
        S_AXI_ARESETN = 0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            h_valid = 1'($urandom_range(0, 1)); h_we = 1'($urandom_range(0, 1));
            h_addr = $urandom_range(0, 15); h_wdata = $urandom; h_wstrb = 4'($urandom);
            f_valid = 1'($urandom_range(0, 1)); f_we = 1'($urandom_range(0, 1));
            f_addr = $urandom_range(0, 15); f_wdata = $urandom; f_wstrb = 4'($urandom);
            @(negedge S_AXI_ACLK);
            n_checks++;
            if ({o_we, o_rd, h_wack, h_rvalid, h_err, f_wack, f_rvalid, f_err} !== 8'b0) begin
                n_errors++;
                $display("FAIL reset_strobes: got %b expected 00000000",
                         {o_we, o_rd, h_wack, h_rvalid, h_err, f_wack, f_rvalid, f_err});
            end
            n_checks++;
            if ({o_waddr, o_wdata, o_wstrb, o_raddr, h_rdata, f_rdata} !== 164'b0) begin
                n_errors++;
                $display("FAIL reset_data: got %h expected 0",
                         {o_waddr, o_wdata, o_wstrb, o_raddr, h_rdata, f_rdata});
            end
        end
        next_cycle();
        drive_idle();
        S_AXI_ARESETN = 1;
        drive_h(1, 32'd3, 32'h1234_5678, 4'hF);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_ready, f_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_first_grant: got h/f ready %b expected 10", {h_ready, f_ready});
        end
        next_cycle();
        drive_idle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_wack, h_err, o_we, o_waddr} !== {1'b1, 1'b0, 1'b1, 32'd3}) begin
            n_errors++;
            $display("FAIL reset_first_write: got wack=%b err=%b we=%b waddr=%0d expected 1 0 1 3",
                     h_wack, h_err, o_we, o_waddr);
        end
    endtask

    task automatic test_host_write_read();
        next_cycle();
        drive_h(1, 32'd5, 32'hAAAA_AAAA, 4'hF);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if (h_ready !== 1'b1) begin
            n_errors++; $display("FAIL hwr_ready: got %b expected 1", h_ready);
        end
        next_cycle();
        drive_idle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({o_we, o_waddr, o_wdata, o_wstrb, h_wack, h_err} !== {1'b1, 32'd5, 32'hAAAA_AAAA, 4'hF, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL hwr_write: got we=%b waddr=%0d wdata=%h wstrb=%h wack=%b err=%b expected 1 5 aaaaaaaa f 1 0",
                     o_we, o_waddr, o_wdata, o_wstrb, h_wack, h_err);
        end
        next_cycle();
        drive_h(0, 32'd5, 32'h0, 4'h0);
        @(negedge S_AXI_ACLK);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            drive_idle();
            @(negedge S_AXI_ACLK);
            if (k == 1) begin
                n_checks++;
                if ({o_rd, o_raddr} !== {1'b1, 32'd5}) begin
                    n_errors++; $display("FAIL hwr_rd_strobe: got rd=%b raddr=%0d expected 1 5", o_rd, o_raddr);
                end
            end
            if (k < 3) begin
                n_checks++;
                if (h_rvalid !== 1'b0) begin
                    n_errors++; $display("FAIL hwr_early_rvalid: got %b expected 0 at N+%0d", h_rvalid, k);
                end
            end else begin
                n_checks++;
                if ({h_rvalid, h_rdata, h_err, f_rvalid} !== {1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0}) begin
                    n_errors++;
                    $display("FAIL hwr_read: got rvalid=%b rdata=%h err=%b f_rvalid=%b expected 1 aaaaaaaa 0 0",
                             h_rvalid, h_rdata, h_err, f_rvalid);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic exp_host;
        logic prev_host;
        int   hcnt;
        int   fcnt;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_idle();
            drive_f(1, 32'(6 + i), 32'hF000 + 32'(i), 4'hF);
            @(negedge S_AXI_ACLK);
            n_checks++;
            if ({h_ready, f_ready} !== 2'b01) begin
                n_errors++; $display("FAIL fab_only_grant: got h/f ready %b expected 01 (cycle %0d)", {h_ready, f_ready}, i);
            end
        end
        exp_host = 1; prev_host = 0; hcnt = 0; fcnt = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive_h(1, 32'd8, 32'hA000 + 32'(hcnt), 4'hF);
            drive_f(1, 32'd9, 32'hB000 + 32'(fcnt), 4'hF);
            @(negedge S_AXI_ACLK);
            n_checks++;
            if ({h_ready, f_ready} !== {exp_host, !exp_host}) begin
                n_errors++;
                $display("FAIL contention_grant: got h/f ready %b expected %b (cycle %0d)",
                         {h_ready, f_ready}, {exp_host, !exp_host}, i);
            end
            if (i > 0) begin
                n_checks++;
                if ({h_wack, f_wack} !== {prev_host, !prev_host}) begin
                    n_errors++;
                    $display("FAIL contention_wack: got h/f wack %b expected %b (cycle %0d)",
                             {h_wack, f_wack}, {prev_host, !prev_host}, i);
                end
            end
            if (exp_host) hcnt++; else fcnt++;
            prev_host = exp_host;
            exp_host  = !exp_host;
        end
        next_cycle();
        drive_idle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_wack, f_wack, o_we, o_waddr, o_wdata} !== {1'b0, 1'b1, 1'b1, 32'd9, 32'hB002}) begin
            n_errors++;
            $display("FAIL contention_last: got h/f wack %b%b we=%b waddr=%0d wdata=%h expected 01 1 9 0000b002",
                     h_wack, f_wack, o_we, o_waddr, o_wdata);
        end
    endtask

    task automatic test_interleaved_reads();
        next_cycle(); drive_idle(); drive_h(1, 32'd1, 32'h11, 4'hF);
        next_cycle(); drive_idle(); drive_f(1, 32'd2, 32'h22, 4'hF);
        next_cycle(); drive_idle(); drive_h(0, 32'd1, 32'h0, 4'h0);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if (h_ready !== 1'b1) begin
            n_errors++; $display("FAIL inter_h_ready: got %b expected 1", h_ready);
        end
        next_cycle(); drive_idle(); drive_f(0, 32'd2, 32'h0, 4'h0);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({f_ready, o_rd, o_raddr} !== {1'b1, 1'b1, 32'd1}) begin
            n_errors++; $display("FAIL inter_f_issue: got ready=%b rd=%b raddr=%0d expected 1 1 1", f_ready, o_rd, o_raddr);
        end
        next_cycle(); drive_idle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({o_rd, o_raddr, h_rvalid, f_rvalid} !== {1'b1, 32'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL inter_n2: got rd=%b raddr=%0d h_rvalid=%b f_rvalid=%b expected 1 2 0 0",
                     o_rd, o_raddr, h_rvalid, f_rvalid);
        end
        next_cycle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_rvalid, h_rdata, f_rvalid} !== {1'b1, 32'h11, 1'b0}) begin
            n_errors++;
            $display("FAIL inter_host_rsp: got h_rvalid=%b h_rdata=%h f_rvalid=%b expected 1 00000011 0",
                     h_rvalid, h_rdata, f_rvalid);
        end
        next_cycle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({f_rvalid, f_rdata, h_rvalid, h_rdata} !== {1'b1, 32'h22, 1'b0, 32'h11}) begin
            n_errors++;
            $display("FAIL inter_fab_rsp: got f_rvalid=%b f_rdata=%h h_rvalid=%b h_rdata=%h expected 1 00000022 0 00000011",
                     f_rvalid, f_rdata, h_rvalid, h_rdata);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle(); drive_idle(); drive_h(0, 32'd1, 32'h0, 4'h0);
        next_cycle(); drive_h(1, 32'd1, 32'h99, 4'hF);
        next_cycle(); drive_h(1, 32'd2, 32'h77, 4'hF);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_wack, h_rvalid} !== 2'b10) begin
            n_errors++; $display("FAIL b2b_first_ack: got wack/rvalid %b expected 10", {h_wack, h_rvalid});
        end
        next_cycle(); drive_idle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_rvalid, h_rdata, h_wack, h_err} !== {1'b1, 32'h11, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_read_old: got rvalid=%b rdata=%h wack=%b err=%b expected 1 00000011 1 0",
                     h_rvalid, h_rdata, h_wack, h_err);
        end
        next_cycle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_wack, h_rvalid, h_err} !== 3'b000) begin
            n_errors++; $display("FAIL b2b_quiet: got wack/rvalid/err %b expected 000", {h_wack, h_rvalid, h_err});
        end
    endtask

    task automatic test_out_of_range();
        next_cycle(); drive_idle(); drive_f(0, 32'd1024, 32'h0, 4'h0);
        next_cycle(); drive_idle(); drive_h(1, 32'd2000, 32'hDEAD_BEEF, 4'hF);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({o_rd, f_wack, f_err} !== 3'b000) begin
            n_errors++; $display("FAIL oor_read_issue: got rd/wack/err %b expected 000", {o_rd, f_wack, f_err});
        end
        next_cycle(); drive_idle(); drive_h(1, 32'd4, 32'h5555_5555, 4'h0);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({o_we, h_wack, h_err, f_err, f_rvalid} !== 5'b01100) begin
            n_errors++;
            $display("FAIL oor_write: got we/wack/err/f_err/f_rvalid %b expected 01100",
                     {o_we, h_wack, h_err, f_err, f_rvalid});
        end
        next_cycle(); drive_idle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({f_rvalid, f_rdata, f_err} !== {1'b1, 32'h0, 1'b1}) begin
            n_errors++;
            $display("FAIL oor_read_rsp: got rvalid=%b rdata=%h err=%b expected 1 00000000 1", f_rvalid, f_rdata, f_err);
        end
        n_checks++;
        if ({o_we, h_wack, h_err} !== 3'b010) begin
            n_errors++; $display("FAIL zero_strb_write: got we/wack/err %b expected 010", {o_we, h_wack, h_err});
        end
    endtask

    task automatic test_reset_in_flight();
        next_cycle(); drive_idle(); drive_h(0, 32'd1, 32'h0, 4'h0);
        next_cycle(); drive_idle(); S_AXI_ARESETN = 0;
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({o_rd, o_raddr, h_rdata} !== 65'b0) begin
            n_errors++; $display("FAIL rif_async_clear: got rd=%b raddr=%0d rdata=%h expected 0 0 0", o_rd, o_raddr, h_rdata);
        end
        next_cycle();
        next_cycle(); S_AXI_ARESETN = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge S_AXI_ACLK);
            n_checks++;
            if ({h_rvalid, f_rvalid, h_wack, f_wack} !== 4'b0) begin
                n_errors++;
                $display("FAIL rif_ghost_rsp: got h/f rvalid,wack %b expected 0000 (cycle %0d)",
                         {h_rvalid, f_rvalid, h_wack, f_wack}, k);
            end
            next_cycle();
        end
        drive_h(0, 32'd1, 32'h0, 4'h0);
        drive_f(0, 32'd2, 32'h0, 4'h0);
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_ready, f_ready} !== 2'b10) begin
            n_errors++; $display("FAIL rif_tie_after_reset: got h/f ready %b expected 10", {h_ready, f_ready});
        end
        next_cycle(); h_valid = 0;
        @(negedge S_AXI_ACLK);
        n_checks++;
        if (f_ready !== 1'b1) begin
            n_errors++; $display("FAIL rif_f_grant: got %b expected 1", f_ready);
        end
        next_cycle(); drive_idle();
        next_cycle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({h_rvalid, h_rdata, f_rvalid} !== {1'b1, 32'h99, 1'b0}) begin
            n_errors++;
            $display("FAIL rif_host_read: got rvalid=%b rdata=%h f_rvalid=%b expected 1 00000099 0", h_rvalid, h_rdata, f_rvalid);
        end
        next_cycle();
        @(negedge S_AXI_ACLK);
        n_checks++;
        if ({f_rvalid, f_rdata, h_rvalid} !== {1'b1, 32'h77, 1'b0}) begin
            n_errors++;
            $display("FAIL rif_fab_read: got rvalid=%b rdata=%h h_rvalid=%b expected 1 00000077 0", f_rvalid, f_rdata, h_rvalid);
        end
    endtask

    task automatic test_random();
        exp_t        wq[$];
        exp_t        rq[$];
        exp_t        e;
        logic [31:0] ref_mem [16];
        logic        model_last;
        bit          pend [2];
        logic        cwe [2];
        logic [31:0] caddr [2];
        logic [31:0] cdata [2];
        logic [3:0]  cstrb [2];
        logic        exp_we, exp_rd;
        logic [31:0] exp_waddr, exp_wdata, exp_raddr;
        logic [3:0]  exp_wstrb;
        logic        ew [2], er [2], ewe [2], ere [2];
        logic [31:0] erd [2];
        logic        aw, ar, ae;
        logic [31:0] ad;
        logic        inr;
        int          g;
        int          pick;
        model_last = 1'b1;
        exp_we = 0; exp_rd = 0;
        exp_waddr = 0; exp_wdata = 0; exp_raddr = 0; exp_wstrb = 0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 0; cwe[r] = 0; caddr[r] = 0; cdata[r] = 0; cstrb[r] = 0;
        end
        for (int c = 0; c < NCYC + 6; c++) begin
            next_cycle();
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && c < NCYC) begin
                    if (c < 16) begin
                        if (r == 0) begin
                            pend[r] = 1; cwe[r] = 1; caddr[r] = 32'(c); cdata[r] = $urandom; cstrb[r] = 4'hF;
                        end
                    end else if ($urandom_range(0, 9) < 7) begin
                        pend[r] = 1;
                        cwe[r]  = 1'($urandom_range(0, 1));
                        cdata[r] = $urandom;
                        cstrb[r] = 4'($urandom_range(0, 15));
                        pick = $urandom_range(0, 19);
                        if (pick < 16)       caddr[r] = 32'($urandom_range(0, 15));
                        else if (pick == 16) caddr[r] = 32'd1024;
                        else if (pick == 17) caddr[r] = 32'd1025;
                        else if (pick == 18) caddr[r] = 32'd2000;
                        else                 caddr[r] = 32'hFFFF_FFFF;
                    end
                end
            end
            h_valid = pend[0]; h_we = cwe[0]; h_addr = caddr[0]; h_wdata = cdata[0]; h_wstrb = cstrb[0];
            f_valid = pend[1]; f_we = cwe[1]; f_addr = caddr[1]; f_wdata = cdata[1]; f_wstrb = cstrb[1];
            @(negedge S_AXI_ACLK);

            for (int r = 0; r < 2; r++) begin
                ew[r] = 0; er[r] = 0; ewe[r] = 0; ere[r] = 0; erd[r] = 0;
            end
            if (wq.size() > 0 && wq[0].cyc == c) begin
                e = wq.pop_front(); ew[e.rid] = 1; ewe[e.rid] = e.err;
            end
            if (rq.size() > 0 && rq[0].cyc == c) begin
                e = rq.pop_front(); er[e.rid] = 1; ere[e.rid] = e.err; erd[e.rid] = e.data;
            end
            for (int r = 0; r < 2; r++) begin
                aw = (r == 1) ? f_wack   : h_wack;
                ar = (r == 1) ? f_rvalid : h_rvalid;
                ae = (r == 1) ? f_err    : h_err;
                ad = (r == 1) ? f_rdata  : h_rdata;
                n_checks++;
                if ({aw, ar} !== {ew[r], er[r]}) begin
                    n_errors++;
                    $display("FAIL rand_rsp: req %0d cycle %0d got wack/rvalid %b expected %b", r, c, {aw, ar}, {ew[r], er[r]});
                end
                n_checks++;
                if (ae !== ((ew[r] & ewe[r]) | (er[r] & ere[r]))) begin
                    n_errors++;
                    $display("FAIL rand_err: req %0d cycle %0d got %b expected %b", r, c, ae, (ew[r] & ewe[r]) | (er[r] & ere[r]));
                end
                if (er[r]) begin
                    n_checks++;
                    if (ad !== erd[r]) begin
                        n_errors++;
                        $display("FAIL rand_rdata: req %0d cycle %0d got %h expected %h", r, c, ad, erd[r]);
                    end
                end
            end

            n_checks++;
            if ({o_we, o_rd} !== {exp_we, exp_rd}) begin
                n_errors++; $display("FAIL rand_mem_strobe: cycle %0d got we/rd %b expected %b", c, {o_we, o_rd}, {exp_we, exp_rd});
            end
            if (exp_we) begin
                n_checks++;
                if ({o_waddr, o_wdata, o_wstrb} !== {exp_waddr, exp_wdata, exp_wstrb}) begin
                    n_errors++;
                    $display("FAIL rand_mem_write: cycle %0d got %h/%h/%h expected %h/%h/%h",
                             c, o_waddr, o_wdata, o_wstrb, exp_waddr, exp_wdata, exp_wstrb);
                end
            end
            if (exp_rd) begin
                n_checks++;
                if (o_raddr !== exp_raddr) begin
                    n_errors++; $display("FAIL rand_mem_read: cycle %0d got raddr %h expected %h", c, o_raddr, exp_raddr);
                end
            end

            g = -1;
            if (pend[0] && pend[1]) g = (model_last == 1'b1) ? 0 : 1;
            else if (pend[0])       g = 0;
            else if (pend[1])       g = 1;
            n_checks++;
            if ({h_ready, f_ready} !== {(g == 0), (g == 1)}) begin
                n_errors++;
                $display("FAIL rand_grant: cycle %0d got h/f ready %b expected %b", c, {h_ready, f_ready}, {(g == 0), (g == 1)});
            end

            exp_we = 0; exp_rd = 0;
            if (g >= 0) begin
                model_last = 1'(g);
                inr = (caddr[g] < MEM_WORDS);
                if (cwe[g]) begin
                    wq.push_back('{c + 1, 1'(g), !inr, 32'h0});
                    if (inr && cstrb[g] != 4'h0) begin
                        exp_we = 1; exp_waddr = caddr[g]; exp_wdata = cdata[g]; exp_wstrb = cstrb[g];
                        for (int b = 0; b < 4; b++) begin
                            if (cstrb[g][b]) ref_mem[caddr[g][3:0]][8*b +: 8] = cdata[g][8*b +: 8];
                        end
                    end
                end else begin
                    rq.push_back('{c + 3, 1'(g), !inr, inr ? ref_mem[caddr[g][3:0]] : 32'h0});
                    exp_rd = inr; exp_raddr = caddr[g];
                end
                pend[g] = 0;
            end
        end
        drive_idle();
        n_checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_errors++;
            $display("FAIL rand_drain: got %0d writes and %0d reads outstanding expected 0 0", wq.size(), rq.size());
        end
    endtask

    initial begin
        drive_idle();
        S_AXI_ARESETN = 0;
        test_reset();
        test_host_write_read();
        test_contention();
        test_interleaved_reads();
        test_back_to_back();
        test_out_of_range();
        test_reset_in_flight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sbus_arbiter.md
Name: sbus_arbiter

Overview:
- Shares one single-port register/memory bus (we/waddr/wdata/wstrb/rd/raddr/rdata, 1-cycle registered read) between two requesters.
- Requester 0 is the host path, driven by the AXI slave front-end in the PS7 GP0 clock domain. Requester 1 is a fabric-side engine, e.g. an LED/status updater or DMA helper.
- Round-robin arbitration, one command per cycle.
- Registered memory-side strobes, tagged read-return routing, and out-of-range address rejection.

Parameters:
- ADDR_W, 32, requester/memory word-address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_WORDS, 1024, number of valid words; an address >= MEM_WORDS is out of range.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- h_valid  in  1  host command valid.
- h_ready  out  1  host command accepted this cycle.
- h_we  in  1  1 = write, 0 = read.
- h_addr  in  ADDR_W  word address.
- h_wdata  in  DATA_W  write data.
- h_wstrb  in  DATA_W/8  byte enables.
- h_wack  out  1  write-complete pulse.
- h_rvalid  out  1  read-data pulse.
- h_rdata  out  DATA_W  read data.
- h_err  out  1  out-of-range flag, qualified by h_wack or h_rvalid.
- f_valid, f_ready, f_we, f_addr, f_wdata, f_wstrb, f_wack, f_rvalid, f_rdata, f_err: fabric requester, same widths and meanings as the h_ ports.
- o_we  out  1  memory write strobe.
- o_waddr  out  ADDR_W  memory write address.
- o_wdata  out  DATA_W  memory write data.
- o_wstrb  out  DATA_W/8  memory byte enables.
- o_rd  out  1  memory read strobe.
- o_raddr  out  ADDR_W  memory read address.
- i_rdata  in  DATA_W  memory read data, valid the cycle after o_rd.

Behaviour:
- Clocking and reset: single clock S_AXI_ACLK; reset S_AXI_ARESETN, asynchronous, active-low.
- Reset values:
  - All registered outputs 0: o_we, o_rd, o_waddr, o_wdata, o_wstrb, o_raddr, *_wack, *_rvalid, *_rdata, *_err.
  - RR pointer last_grant = fabric, so host wins the first tie.
- Arbitration (combinational grant, cycle N):
  - Exactly one valid → that requester is granted.
  - Both valid → the requester not in last_grant is granted.
  - last_grant updates only on a grant.
  - x_ready = grant_x, combinational from x_valid and last_grant. Accept = x_valid & x_ready.
  - x_ready is never high without x_valid.
  - A requester holds its command stable until accepted.
- Command stage (registered at the end of N, visible in N+1):
  - In-range write → o_we=1 with addr/data/strb.
  - In-range write with wstrb==0 → accepted and acked, but o_we stays 0.
  - In-range read → o_rd=1, o_raddr=addr.
  - Out of range → no memory strobe.
  - Strobes are single-cycle pulses and drop to 0 when nothing is accepted.
  - Address/data registers hold their last value when idle.
- Write response: x_wack=1 during N+1, with x_err = out-of-range.
- Read path: a tag {id, err} is pipelined alongside o_rd.
  - i_rdata is sampled at the end of N+2 (valid in N+2) into x_rdata of the tagged requester.
  - x_rvalid=1 during N+3; the other requester's rdata is unchanged.
  - Out-of-range read: x_rvalid in N+3 with x_rdata=0, x_err=1.
- Latency and throughput:
  - Write accept→wack: 1 cycle. Read accept→rvalid: 3 cycles.
  - Throughput: 1 command per cycle, fully pipelined.
  - Responses return in acceptance order per requester; requesters cannot stall responses.
- Simultaneous events:
  - A read response and a write ack for the same requester in the same cycle are both asserted.
  - A back-to-back read then write to the same address: the read returns the pre-write value, because the memory read precedes the write by one cycle.
- *_err is valid only while *_wack or *_rvalid is high; 0 otherwise.
- Reset mid-operation: the in-flight pipeline is cleared and no response is issued for commands accepted before reset. Requesters must discard outstanding expectations.

Decomposition:
- Package sbus_pkg:
  - REQ_HOST=0, REQ_FAB=1.
  - Typedef sbus_cmd_t {we, addr, wdata, wstrb}.
  - Typedef sbus_tag_t {id, err, is_rd}.
- One sub-module, sbus_rr_arb2: 2-way round-robin grant plus last_grant register.
- The rest lives in sbus_arbiter: command register, tag pipeline, response demux.

Test Plan:
- Reset: hold ARESETN=0 while toggling inputs → all outputs 0; release, h_valid only → h_ready=1 the same cycle.
- Host write then read:
  - Write addr 5, data 0xAAAAAAAA, wstrb 0xF → o_we in N+1 with waddr 5; h_wack in N+1, h_err=0.
  - Read addr 5 with memory model returning 0xAAAAAAAA → h_rvalid in N+3, h_rdata=0xAAAAAAAA.
- Contention:
  - Both valid continuously for 6 cycles → grants H,F,H,F,H,F.
  - Only f_valid → F granted every cycle.
- Interleaved reads: H reads addr 1 (mem 0x11), F reads addr 2 (mem 0x22) in consecutive cycles → h_rvalid/0x11 and f_rvalid/0x22 on consecutive cycles, with no cross-delivery.
- Out of range:
  - f read addr 1024 (MEM_WORDS=1024) → no o_rd; f_rvalid in N+3 with f_rdata=0, f_err=1.
  - h write addr 2000 → no o_we; h_wack, h_err=1.
- Reset in flight: accept a read, assert reset in N+1 → no rvalid is ever produced for it; after release the next read behaves normally.
